vid_frame_ctrl: RTL and testbench

- Sequences the pixel pipeline that sits behind the RGB-to-YCbCr converter.
- Tracks the h_sync/v_sync/de stream to produce per-pixel x/y coordinates and frame/line event pulses.
- Double-buffers the 32-bit colour-threshold configuration (Cb/Cr min/max) used by the downstream segmentation stage, so changes apply only at frame boundaries.
- Sits in parallel with the colour converter. Its outputs are aligned one cycle after the sync inputs.

---
 rtl/vid_pkg.sv | 20 ++
 rtl/vid_edge_det.sv | 25 ++
 rtl/vid_frame_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_vid_frame_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared types and constants for the video frame controller slice.
package vid_pkg;

  typedef enum logic [1:0] {
    StSyncWait,
    StVblank,
    StActive,
    StHblank
  } vid_state_e;

  localparam int unsigned CFG_W = 32;

  // Threshold field layout: {cr_max, cr_min, cb_max, cb_min}
  localparam int unsigned FIELD_W    = 8;
  localparam int unsigned CB_MIN_LSB = 0;
  localparam int unsigned CB_MAX_LSB = 8;
  localparam int unsigned CR_MIN_LSB = 16;
  localparam int unsigned CR_MAX_LSB = 24;

endpackage

// File: rtl/vid_edge_det.sv
// Registers a single-bit signal and flags its rising and falling edges.
module vid_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic sig_q_o,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign sig_q_o = sig_q;
  assign rise_o  = sig_i & ~sig_q;
  assign fall_o  = ~sig_i & sig_q;

endmodule

// File: rtl/vid_frame_ctrl.sv
// Frame/line sequencer for the pixel pipeline: coordinates, event pulses, sticky
// timing errors and frame-boundary double-buffering of the colour thresholds.
module vid_frame_ctrl
  import vid_pkg::*;
#(
  parameter int unsigned      H_ACTIVE = 1280,
  parameter int unsigned      V_ACTIVE = 720,
  parameter int unsigned      X_W      = 11,
  parameter int unsigned      Y_W      = 10,
  parameter logic [CFG_W-1:0] CFG_INIT = 32'h00FF00FF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  input  logic             de_sync_in,
  input  logic             cfg_wr_en,
  input  logic [CFG_W-1:0] cfg_wr_data,
  input  logic             err_clr,
  output logic             h_sync_out,
  output logic             v_sync_out,
  output logic             de_sync_out,
  output logic [X_W-1:0]   x_pos,
  output logic [Y_W-1:0]   y_pos,
  output logic             frame_start,
  output logic             line_end,
  output logic             frame_end,
  output logic [CFG_W-1:0] cfg_active,
  output logic             cfg_pending,
  output logic [15:0]      frame_cnt,
  output logic             locked,
  output logic             err_hlen,
  output logic             err_vlen
);

  localparam logic [X_W-1:0] XMax = '1;

  vid_state_e state_q, state_d;

  logic v_rise, v_fall_unused, de_rise, de_fall;
  logic h_q;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic frame_start_q, frame_start_d;
  logic line_end_q, line_end_d;
  logic frame_end_q, frame_end_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic frame_done_q, frame_done_d;
  logic locked_q, err_hlen_q, err_vlen_q;
  logic hlen_evt, vlen_evt;
  logic [CFG_W-1:0] cfg_active_q, cfg_active_d, cfg_shadow_q, cfg_shadow_d;
  logic cfg_pending_q, cfg_pending_d;
  logic [X_W:0] run_len;
  logic last_line;

  vid_edge_det u_vsync_det (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (v_sync_in),
    .sig_q_o (v_sync_out),
    .rise_o  (v_rise),
    .fall_o  (v_fall_unused)
  );

  vid_edge_det u_de_det (
    .clk     (clk),
    .rst     (rst),
    .sig_i   (de_sync_in),
    .sig_q_o (de_sync_out),
    .rise_o  (de_rise),
    .fall_o  (de_fall)
  );

  // x_q holds the last pixel index, so the run length is one more.
  assign run_len   = {1'b0, x_q} + 1'b1;
  assign last_line = (y_q == Y_W'(V_ACTIVE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSyncWait;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (v_rise) begin
      state_d = StVblank;
    end else begin
      unique case (state_q)
        StSyncWait: state_d = StSyncWait;
        StVblank, StHblank: begin
          if (de_rise) state_d = StActive;
        end
        StActive: begin
          if (de_fall) state_d = last_line ? StVblank : StHblank;
        end
        default: state_d = StSyncWait;
      endcase
    end
  end

  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    line_end_d    = 1'b0;
    frame_end_d   = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    frame_done_d  = frame_done_q;
    hlen_evt      = 1'b0;
    vlen_evt      = 1'b0;
    if (v_rise) begin
      frame_done_d = 1'b0;
      vlen_evt     = (state_q == StActive) || (state_q == StHblank);
    end else begin
      unique case (state_q)
        StVblank: begin
          if (de_rise) begin
            x_d           = '0;
            y_d           = '0;
            frame_start_d = 1'b1;
            // A new frame without a v_sync edge means too many lines.
            vlen_evt      = frame_done_q;
            frame_done_d  = 1'b0;
          end
        end
        StHblank: begin
          if (de_rise) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end
        end
        StActive: begin
          if (de_fall) begin
            line_end_d = 1'b1;
            hlen_evt   = (run_len != (X_W + 1)'(H_ACTIVE));
            if (last_line) begin
              frame_end_d  = 1'b1;
              frame_cnt_d  = frame_cnt_q + 16'd1;
              frame_done_d = 1'b1;
            end
          end else if (de_sync_in && (x_q != XMax)) begin
            x_d = x_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A write coincident with the boundary bypasses the shadow straight into force.
  always_comb begin
    cfg_active_d  = cfg_active_q;
    cfg_shadow_d  = cfg_shadow_q;
    cfg_pending_d = cfg_pending_q;
    if (v_rise) begin
      if (cfg_wr_en) begin
        cfg_active_d = cfg_wr_data;
        cfg_shadow_d = cfg_wr_data;
      end else if (cfg_pending_q) begin
        cfg_active_d = cfg_shadow_q;
      end
      cfg_pending_d = 1'b0;
    end else if (cfg_wr_en) begin
      cfg_shadow_d  = cfg_wr_data;
      cfg_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q           <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_cnt_q   <= '0;
      frame_done_q  <= 1'b0;
      locked_q      <= 1'b0;
      err_hlen_q    <= 1'b0;
      err_vlen_q    <= 1'b0;
      cfg_active_q  <= CFG_INIT;
      cfg_shadow_q  <= CFG_INIT;
      cfg_pending_q <= 1'b0;
    end else begin
      h_q           <= h_sync_in;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      frame_end_q   <= frame_end_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_done_q  <= frame_done_d;
      locked_q      <= locked_q | v_rise;
      err_hlen_q    <= (err_hlen_q & ~err_clr) | hlen_evt;
      err_vlen_q    <= (err_vlen_q & ~err_clr) | vlen_evt;
      cfg_active_q  <= cfg_active_d;
      cfg_shadow_q  <= cfg_shadow_d;
      cfg_pending_q <= cfg_pending_d;
    end
  end

  assign h_sync_out  = h_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign frame_start = frame_start_q;
  assign line_end    = line_end_q;
  assign frame_end   = frame_end_q;
  assign frame_cnt   = frame_cnt_q;
  assign locked      = locked_q;
  assign err_hlen    = err_hlen_q;
  assign err_vlen    = err_vlen_q;
  assign cfg_active  = cfg_active_q;
  assign cfg_pending = cfg_pending_q;

endmodule

// File: tb/tb_vid_frame_ctrl.sv
// Directed bench for vid_frame_ctrl with a 4x3 active frame.
module tb_vid_frame_ctrl;

  localparam int unsigned H_ACTIVE = 4;
  localparam int unsigned V_ACTIVE = 3;
  localparam logic [31:0] CFG_INIT = 32'h00FF00FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        h_sync_in, v_sync_in, de_sync_in;
  logic        cfg_wr_en;
  logic [31:0] cfg_wr_data;
  logic        err_clr;
  logic        h_sync_out, v_sync_out, de_sync_out;
  logic [10:0] x_pos;
  logic [9:0]  y_pos;
  logic        frame_start, line_end, frame_end;
  logic [31:0] cfg_active;
  logic        cfg_pending;
  logic [15:0] frame_cnt;
  logic        locked, err_hlen, err_vlen;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int le_cnt = 0;
  int fe_cnt = 0;
  int fs_base, le_base, fe_base;

  vid_frame_ctrl #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .X_W      (11),
    .Y_W      (10),
    .CFG_INIT (CFG_INIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .h_sync_in   (h_sync_in),
    .v_sync_in   (v_sync_in),
    .de_sync_in  (de_sync_in),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_wr_data (cfg_wr_data),
    .err_clr     (err_clr),
    .h_sync_out  (h_sync_out),
    .v_sync_out  (v_sync_out),
    .de_sync_out (de_sync_out),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .frame_start (frame_start),
    .line_end    (line_end),
    .frame_end   (frame_end),
    .cfg_active  (cfg_active),
    .cfg_pending (cfg_pending),
    .frame_cnt   (frame_cnt),
    .locked      (locked),
    .err_hlen    (err_hlen),
    .err_vlen    (err_vlen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    fs_cnt <= fs_cnt + int'(frame_start);
    le_cnt <= le_cnt + int'(line_end);
    fe_cnt <= fe_cnt + int'(frame_end);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic h, input logic v, input logic de);
    h_sync_in  = h;
    v_sync_in  = v;
    de_sync_in = de;
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    fs_base = fs_cnt;
    le_base = le_cnt;
    fe_base = fe_cnt;
  endtask

  task automatic vs();
    cyc(1'b0, 1'b1, 1'b0);
    chk("v_sync_out", 32'(v_sync_out), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic drive_line(input int n, input int exp_y, input bit track, input bit exp_fs,
                            input bit exp_fe, input bit clr);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("de_sync_out", 32'(de_sync_out), 32'd1);
      chk("x_pos", 32'(x_pos), track ? 32'(i) : 32'd0);
      chk("y_pos", 32'(y_pos), track ? 32'(exp_y) : 32'd0);
      chk("frame_start", 32'(frame_start), 32'((i == 0) && exp_fs && track));
    end
    err_clr = clr;
    cyc(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("line_end", 32'(line_end), 32'(track));
    chk("frame_end", 32'(frame_end), 32'(exp_fe));
    chk("de_low", 32'(de_sync_out), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("h_sync_out", 32'(h_sync_out), 32'd1);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset();
    chk("rst_h", 32'(h_sync_out), 32'd0);
    chk("rst_v", 32'(v_sync_out), 32'd0);
    chk("rst_de", 32'(de_sync_out), 32'd0);
    chk("rst_x", 32'(x_pos), 32'd0);
    chk("rst_y", 32'(y_pos), 32'd0);
    chk("rst_pulses", 32'({frame_start, line_end, frame_end}), 32'd0);
    chk("rst_cfg_active", cfg_active, CFG_INIT);
    chk("rst_cfg_pending", 32'(cfg_pending), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_errs", 32'({err_hlen, err_vlen}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    h_sync_in = 1'b0; v_sync_in = 1'b0; de_sync_in = 1'b0;
    cfg_wr_en = 1'b0; cfg_wr_data = '0; err_clr = 1'b0;
    #1;
    chk_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset();

    // Unlocked: de runs are ignored.
    snap();
    for (int l = 0; l < 3; l++) drive_line(4, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("unlocked_locked", 32'(locked), 32'd0);
    chk("unlocked_pulses", 32'(fs_cnt - fs_base + le_cnt - le_base + fe_cnt - fe_base), 32'd0);

    // First good frame.
    vs();
    chk("locked", 32'(locked), 32'd1);
    snap();
    drive_line(4, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_line(4, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_line(4, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("f1_line_ends", 32'(le_cnt - le_base), 32'd3);
    chk("f1_frame_starts", 32'(fs_cnt - fs_base), 32'd1);
    chk("f1_frame_ends", 32'(fe_cnt - fe_base), 32'd1);
    chk("f1_errs", 32'({err_hlen, err_vlen}), 32'd0);

    // Long line sets err_hlen, which sticks.
    vs();
    drive_line(4, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_line(5, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hlen_set", 32'(err_hlen), 32'd1);
    drive_line(4, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("hlen_sticky", 32'(err_hlen), 32'd1);
    chk("f2_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("f2_vlen", 32'(err_vlen), 32'd0);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("hlen_cleared", 32'(err_hlen), 32'd0);

    // err_clr on the same cycle as a short line's end: set wins.
    vs();
    drive_line(3, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("hlen_set_wins", 32'(err_hlen), 32'd1);
    drive_line(4, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_line(4, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("f3_frame_cnt", 32'(frame_cnt), 32'd3);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;

    // v_sync after only two lines.
    vs();
    snap();
    drive_line(4, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_line(4, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("vlen_before", 32'(err_vlen), 32'd0);
    vs();
    chk("vlen_early_vsync", 32'(err_vlen), 32'd1);
    chk("early_no_frame_end", 32'(fe_cnt - fe_base), 32'd0);
    chk("early_frame_cnt", 32'(frame_cnt), 32'd3);
    drive_line(4, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_line(4, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_line(4, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("f4_frame_cnt", 32'(frame_cnt), 32'd4);
    chk("vlen_sticky", 32'(err_vlen), 32'd1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    chk("vlen_cleared", 32'(err_vlen), 32'd0);

    // New frame starting without a v_sync edge.
    drive_line(4, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("vlen_no_vsync", 32'(err_vlen), 32'd1);
    drive_line(4, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_line(4, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("f5_frame_cnt", 32'(frame_cnt), 32'd5);
    err_clr = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;

    // Mid-frame config write applies at the next boundary.
    vs();
    drive_line(4, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    cfg_wr_en = 1'b1; cfg_wr_data = 32'h11223344;
    cyc(1'b0, 1'b0, 1'b0);
    cfg_wr_en = 1'b0;
    chk("cfg_pending_set", 32'(cfg_pending), 32'd1);
    chk("cfg_active_held", cfg_active, CFG_INIT);
    drive_line(4, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_line(4, 2, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("cfg_still_pending", 32'(cfg_pending), 32'd1);
    chk("cfg_still_held", cfg_active, CFG_INIT);
    vs();
    chk("cfg_applied", cfg_active, 32'h11223344);
    chk("cfg_pending_clr", 32'(cfg_pending), 32'd0);
    chk("f6_errs", 32'({err_hlen, err_vlen}), 32'd0);

    // Last write before the boundary wins.
    cfg_wr_en = 1'b1; cfg_wr_data = 32'h55555555;
    cyc(1'b0, 1'b0, 1'b0);
    cfg_wr_data = 32'h66666666;
    cyc(1'b0, 1'b0, 1'b0);
    cfg_wr_en = 1'b0;
    chk("cfg_hold2", cfg_active, 32'h11223344);
    vs();
    chk("cfg_last_wins", cfg_active, 32'h66666666);

    // Write coincident with the edge takes effect directly.
    cfg_wr_en = 1'b1; cfg_wr_data = 32'hAABBCCDD;
    cyc(1'b0, 1'b1, 1'b0);
    cfg_wr_en = 1'b0;
    chk("cfg_same_cycle", cfg_active, 32'hAABBCCDD);
    chk("cfg_same_pending", 32'(cfg_pending), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);

    // Reset mid-line.
    vs();
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("pre_rst_x", 32'(x_pos), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset();
    snap();
    cyc(1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("post_rst_pulses", 32'(fs_cnt - fs_base + le_cnt - le_base + fe_cnt - fe_base), 32'd0);
    chk("post_rst_locked", 32'(locked), 32'd0);
    chk("post_rst_cfg", cfg_active, CFG_INIT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
